layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameters, one per line:
  - WIDTH, 240, pixels per line
  - HEIGHT, 320, lines per frame
  - X_BITS, 8, xCount/xAddr width
  - Y_BITS, 9, yCount/yAddr width
  - LAYERS, 4, layer count (1..8)
  - BG_COLOUR, 16'hFFFF, RGB565 background colour
REQ-002 SHALL have ports, one per line:
  - clock  in  1  sole clock
  - reset  in  1  asynchronous, active-high reset
  - pixelReady  in  1  display accepts pixel this cycle
  - layerHit  in  LAYERS  per-layer hit for current xCount/yCount; bit 0 highest priority
  - layerColour  in  16*LAYERS  RGB565 colour per layer; layer i at bits [16i+15:16i]
  - layerEnableIn  in  LAYERS  requested layer enables
  - fillModeIn  in  1  requested fill mode
  - fillColour  in  16  colour used in fill mode
  - xCount  out  X_BITS  scan column
  - yCount  out  Y_BITS  scan line
  - xAddr  out  X_BITS  registered pixel column
  - yAddr  out  Y_BITS  registered pixel line
  - pixelData  out  16  registered pixel colour
  - pixelWrite  out  1  write strobe to display
  - frameDone  out  1  one-cycle end-of-frame pulse
  - frameCount  out  8  completed-frame counter

Function
REQ-003 pixelWrite SHALL be 1 from the first clock edge after reset deasserts, and SHALL stay 1.
REQ-004 xCount SHALL advance by 1 on every cycle with pixelReady=1.
REQ-005 xCount SHALL wrap from WIDTH-1 to 0.
REQ-006 yCount SHALL advance by 1 only on a cycle with pixelReady=1 and xCount=WIDTH-1.
REQ-007 yCount SHALL wrap from HEIGHT-1 to 0.
REQ-008 With pixelReady=0, xCount, yCount, xAddr, yAddr, pixelData and frameCount SHALL hold.
REQ-009 On a cycle with pixelReady=1, the module SHALL register xAddr<=xCount, yAddr<=yCount and pixelData<=composite colour, giving 1-cycle latency.
REQ-010 Composite colour: if the fillMode shadow is 1, fillColour; otherwise the layerColour of the lowest-index i with layerHit[i]=1 and enable-shadow bit i=1; otherwise BG_COLOUR.
REQ-011 Hits on disabled layers SHALL be ignored.
REQ-012 With multiple enabled hits, the lowest index SHALL win.
REQ-013 Enable shadow (LAYERS bits) and fillMode shadow SHALL load from layerEnableIn and fillModeIn only on the frame-boundary cycle (pixelReady=1, xCount=WIDTH-1, yCount=HEIGHT-1), so mode changes never tear mid-frame.
REQ-014 On the frame-boundary cycle, the pixel for (WIDTH-1, HEIGHT-1) SHALL use the old shadows, and the new shadows SHALL apply from pixel (0,0).
REQ-015 frameDone SHALL be 1 for exactly the cycle following the frame-boundary cycle, and 0 otherwise.
REQ-016 frameCount SHALL increment on the frame-boundary cycle and wrap from 255 to 0.
REQ-017 layerHit, layerColour and fillColour SHALL be sampled combinationally in the pixelReady cycle, with no extra pipeline stage.

Reset
REQ-018 On reset assertion, the module SHALL immediately set xCount=0, yCount=0, xAddr=0, yAddr=0, pixelData=0, pixelWrite=0, frameDone=0, frameCount=0, enable shadow all ones and fillMode shadow 0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame with no frameDone pulse, and scanning SHALL restart at (0,0) after release.
REQ-020 The module SHALL ignore all inputs while reset is asserted.

Verification
REQ-021 Reset release with pixelReady held 1 and layerHit=0 -> pixelWrite=1 after 1 cycle; pixelData=16'hFFFF with xAddr/yAddr tracking 0,1,2,...; frameDone pulses after exactly 76800 ready cycles; frameCount=1.
REQ-022 layerHit=4'b0110 with colours L1=16'h001F and L2=16'hF800, all enabled -> pixelData=16'h001F; after disabling L1 and crossing a frame boundary -> pixelData=16'hF800.
REQ-023 layerEnableIn changed at pixel (100,50) -> output unchanged until (0,0) of the next frame; the new enables apply from (0,0).
REQ-024 fillModeIn=1 with fillColour=16'h07E0 held over a boundary -> every pixel of the next frame is 16'h07E0 regardless of layerHit.
REQ-025 pixelReady toggled with a random pattern -> counters, addresses and data hold on 0-cycles, and the pixel sequence is identical to the always-ready case.
REQ-026 Reset pulsed at (200,300) -> all outputs zero immediately; no frameDone; scanning restarts at (0,0); frameCount continues from 0.

Source files
------------

// File: rtl/layer_compositor.sv
// Layer compositor: raster-scans a WIDTH x HEIGHT frame and emits one RGB565 pixel per
// ready cycle, chosen by layer priority, fill mode or background colour.
module layer_compositor #(
  parameter int          WIDTH     = 240,
  parameter int          HEIGHT    = 320,
  parameter int          X_BITS    = 8,
  parameter int          Y_BITS    = 9,
  parameter int          LAYERS    = 4,
  parameter logic [15:0] BG_COLOUR = 16'hFFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pixelReady,
  input  logic [LAYERS-1:0]      layerHit,
  input  logic [16*LAYERS-1:0]   layerColour,
  input  logic [LAYERS-1:0]      layerEnableIn,
  input  logic                   fillModeIn,
  input  logic [15:0]            fillColour,
  output logic [X_BITS-1:0]      xCount,
  output logic [Y_BITS-1:0]      yCount,
  output logic [X_BITS-1:0]      xAddr,
  output logic [Y_BITS-1:0]      yAddr,
  output logic [15:0]            pixelData,
  output logic                   pixelWrite,
  output logic                   frameDone,
  output logic [7:0]             frameCount
);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic [X_BITS-1:0] r_xaddr;
  logic [Y_BITS-1:0] r_yaddr;
  logic [15:0]       r_pixel;
  logic              r_write;
  logic              r_done;
  logic [7:0]        r_frames;
  logic [LAYERS-1:0] r_en;
  logic              r_fill;

  logic              w_xend;
  logic              w_yend;
  logic              w_last;
  logic [15:0]       w_pick;
  logic [15:0]       w_colour;

  assign w_xend = (r_x == X_BITS'(WIDTH - 1));
  assign w_yend = (r_y == Y_BITS'(HEIGHT - 1));
  assign w_last = pixelReady & w_xend & w_yend;

  // Walk from the lowest priority upward so the lowest enabled hit index overwrites last.
  always_comb begin
    w_pick = BG_COLOUR;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layerHit[i] && r_en[i]) begin
        w_pick = layerColour[16*i +: 16];
      end else begin
        w_pick = w_pick;
      end
    end
    if (r_fill) begin
      w_colour = fillColour;
    end else begin
      w_colour = w_pick;
    end
  end

  // Scan counters, output pixel register, frame pulse and mode shadows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_xaddr  <= '0;
      r_yaddr  <= '0;
      r_pixel  <= 16'h0000;
      r_write  <= 1'b0;
      r_done   <= 1'b0;
      r_frames <= 8'd0;
      r_en     <= {LAYERS{1'b1}};
      r_fill   <= 1'b0;
    end else begin
      r_write <= 1'b1;
      r_done  <= w_last;
      if (pixelReady) begin
        r_xaddr <= r_x;
        r_yaddr <= r_y;
        r_pixel <= w_colour;
        r_x     <= w_xend ? '0 : r_x + X_BITS'(1);
        if (w_xend) begin
          r_y <= w_yend ? '0 : r_y + Y_BITS'(1);
        end
        // Shadows change only here, so the closing pixel still uses the old modes.
        if (w_last) begin
          r_en     <= layerEnableIn;
          r_fill   <= fillModeIn;
          r_frames <= r_frames + 8'd1;
        end
      end
    end
  end

  assign xCount     = r_x;
  assign yCount     = r_y;
  assign xAddr      = r_xaddr;
  assign yAddr      = r_yaddr;
  assign pixelData  = r_pixel;
  assign pixelWrite = r_write;
  assign frameDone  = r_done;
  assign frameCount = r_frames;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor on a reduced 12x5 frame: vector table plus
// sequences for shadow timing, fill mode, ready stalls and mid-frame reset.
module tb_layer_compositor;

  localparam int W = 12;
  localparam int H = 5;
  localparam int XB = 8;
  localparam int YB = 9;
  localparam int L = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            pixelReady = 1'b0;
  logic [L-1:0]    layerHit = '0;
  logic [16*L-1:0] layerColour = '0;
  logic [L-1:0]    layerEnableIn = '1;
  logic            fillModeIn = 1'b0;
  logic [15:0]     fillColour = 16'h0000;
  logic [XB-1:0]   xCount;
  logic [YB-1:0]   yCount;
  logic [XB-1:0]   xAddr;
  logic [YB-1:0]   yAddr;
  logic [15:0]     pixelData;
  logic            pixelWrite;
  logic            frameDone;
  logic [7:0]      frameCount;

  layer_compositor #(
    .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB), .LAYERS(L), .BG_COLOUR(16'hFFFF)
  ) dut (
    .clock(clock), .reset(reset), .pixelReady(pixelReady), .layerHit(layerHit),
    .layerColour(layerColour), .layerEnableIn(layerEnableIn), .fillModeIn(fillModeIn),
    .fillColour(fillColour), .xCount(xCount), .yCount(yCount), .xAddr(xAddr),
    .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .frameDone(frameDone), .frameCount(frameCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_x, m_y, m_xa, m_ya, m_fc;
  logic [15:0] m_pd;
  logic        m_pw, m_fd, m_fill;
  logic [L-1:0] m_en;

  typedef struct {
    logic [L-1:0] en;
    logic         fill;
    logic [L-1:0] hit;
    logic [15:0]  exp;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_comp();
    if (m_fill) return fillColour;
    for (int i = 0; i < L; i++)
      if (layerHit[i] && m_en[i]) return layerColour[16*i +: 16];
    return 16'hFFFF;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_xa = 0; m_ya = 0; m_fc = 0;
    m_pd = 16'h0000; m_pw = 1'b0; m_fd = 1'b0; m_fill = 1'b0; m_en = '1;
  endtask

  task automatic chk_all();
    chk("xCount", int'(xCount), m_x);
    chk("yCount", int'(yCount), m_y);
    chk("xAddr", int'(xAddr), m_xa);
    chk("yAddr", int'(yAddr), m_ya);
    chk("pixelData", int'(pixelData), int'(m_pd));
    chk("pixelWrite", int'(pixelWrite), int'(m_pw));
    chk("frameDone", int'(frameDone), int'(m_fd));
    chk("frameCount", int'(frameCount), m_fc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, int'(xCount), 0);
    chk({tag, "_y"}, int'(yCount), 0);
    chk({tag, "_xa"}, int'(xAddr), 0);
    chk({tag, "_ya"}, int'(yAddr), 0);
    chk({tag, "_pd"}, int'(pixelData), 0);
    chk({tag, "_pw"}, int'(pixelWrite), 0);
    chk({tag, "_fd"}, int'(frameDone), 0);
    chk({tag, "_fc"}, int'(frameCount), 0);
  endtask

  // One clock with the given ready; inputs are already stable, checks run #1 after the edge.
  task automatic tick(input logic rdy);
    logic [15:0] c;
    logic        bnd;
    pixelReady = rdy;
    c   = model_comp();
    bnd = rdy && (m_x == W - 1) && (m_y == H - 1);
    @(posedge clock);
    #1;
    m_pw = 1'b1;
    m_fd = bnd;
    if (rdy) begin
      m_xa = m_x; m_ya = m_y; m_pd = c;
      if (bnd) begin
        m_en = layerEnableIn; m_fill = fillModeIn; m_fc = (m_fc + 1) % 256;
      end
      if (m_x == W - 1) begin
        m_x = 0;
        m_y = (m_y == H - 1) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
    end
    chk_all();
  endtask

  task automatic to_frame_start();
    int n;
    n = 0;
    do begin
      tick(1'b1);
      n++;
    end while (!(m_x == 0 && m_y == 0) && n < 500);
    chk("frame_start_reached", int'(m_x == 0 && m_y == 0), 1);
  endtask

  initial begin
    int n;
    // Hit rows under all-enabled, then L1 disabled, then fill mode.
    vt[0]  = '{4'b1111, 1'b0, 4'b0000, 16'hFFFF};
    vt[1]  = '{4'b1111, 1'b0, 4'b0001, 16'h1111};
    vt[2]  = '{4'b1111, 1'b0, 4'b0110, 16'h001F};
    vt[3]  = '{4'b1111, 1'b0, 4'b0100, 16'hF800};
    vt[4]  = '{4'b1111, 1'b0, 4'b1000, 16'hABCD};
    vt[5]  = '{4'b1111, 1'b0, 4'b1111, 16'h1111};
    vt[6]  = '{4'b1111, 1'b0, 4'b1100, 16'hF800};
    vt[7]  = '{4'b1111, 1'b0, 4'b1010, 16'h001F};
    vt[8]  = '{4'b1101, 1'b0, 4'b0110, 16'hF800};
    vt[9]  = '{4'b1101, 1'b0, 4'b0010, 16'hFFFF};
    vt[10] = '{4'b1101, 1'b0, 4'b1010, 16'hABCD};
    vt[11] = '{4'b1101, 1'b1, 4'b1111, 16'h07E0};

    // Reset asserted: outputs clear at once and inputs are ignored.
    #1 reset = 1'b1;
    pixelReady = 1'b1; layerHit = 4'b1111; fillModeIn = 1'b1; layerEnableIn = 4'b0000;
    layerColour = {16'hABCD, 16'hF800, 16'h001F, 16'h1111};
    fillColour = 16'h07E0;
    #1 chk_zero("rst_async");
    repeat (3) @(posedge clock);
    #1 chk_zero("rst_hold");

    // Release with ready held and no hits: background pixels, frame of W*H cycles.
    layerHit = 4'b0000; fillModeIn = 1'b0; layerEnableIn = 4'b1111;
    reset = 1'b0;
    model_reset();
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      tick(1'b1);
      n = k;
      if (k <= W) begin
        chk("first_xaddr", int'(xAddr), k - 1);
        chk("first_pixel", int'(pixelData), 16'hFFFF);
      end
      if (frameDone) break;
    end
    chk("frame_len", n, W * H);
    chk("frame_count1", int'(frameCount), 1);
    tick(1'b1);
    chk("done_one_cycle", int'(frameDone), 0);

    // Vector table: change shadows via a frame crossing when the row needs it.
    fillColour = 16'h07E0;
    for (int r = 0; r < 12; r++) begin
      if (vt[r].en != m_en || vt[r].fill != m_fill) begin
        layerEnableIn = vt[r].en;
        fillModeIn = vt[r].fill;
        to_frame_start();
      end
      layerHit = vt[r].hit;
      tick(1'b1);
      chk($sformatf("vec%0d", r), int'(pixelData), int'(vt[r].exp));
    end

    // Enable change mid-frame must not tear: old enables until (0,0).
    layerEnableIn = 4'b1111; fillModeIn = 1'b0;
    to_frame_start();
    to_frame_start();
    layerHit = 4'b0110;
    repeat (30) tick(1'b1);
    layerEnableIn = 4'b1101;
    for (int k = 0; k < W * H - 30; k++) begin
      tick(1'b1);
      chk("no_tear", int'(pixelData), 16'h001F);
    end
    tick(1'b1);
    chk("new_en_at_origin_x", int'(xAddr), 0);
    chk("new_en_at_origin_pd", int'(pixelData), 16'hF800);

    // Fill mode held over a boundary: whole next frame is fillColour.
    fillModeIn = 1'b1;
    to_frame_start();
    for (int k = 0; k < W * H; k++) begin
      layerHit = 4'($urandom_range(0, 15));
      tick(1'b1);
      chk("fill_frame", int'(pixelData), 16'h07E0);
    end
    fillModeIn = 1'b0; layerEnableIn = 4'b1111;
    to_frame_start();

    // Random ready stalls, hits tied to position so the pixel stream is reproducible.
    for (int k = 0; k < 300; k++) begin
      layerHit = 4'((m_x + m_y) % 16);
      tick(1'($urandom_range(0, 1)));
    end

    // Reset mid-frame at (9,3): immediate clear, no frameDone, restart from origin.
    n = 0;
    while (!(m_x == 9 && m_y == 3) && n < 200) begin
      tick(1'b1);
      n++;
    end
    chk("reach_9_3", int'(m_x == 9 && m_y == 3), 1);
    reset = 1'b1;
    #1 chk_zero("midrst");
    repeat (2) @(posedge clock);
    #1 chk_zero("midrst_hold");
    reset = 1'b0;
    model_reset();
    layerHit = 4'b0000;
    tick(1'b1);
    chk("restart_xaddr", int'(xAddr), 0);
    chk("restart_yaddr", int'(yAddr), 0);
    n = 1;
    while (!frameDone && n < 200) begin
      tick(1'b1);
      n++;
    end
    chk("post_rst_frame_len", n, W * H);
    chk("post_rst_frame_count", int'(frameCount), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
